// File: rtl/dataflow_elastic_fifo.sv
// dataflow_elastic_fifo: registered valid/ready FIFO of DEPTH tokens between dataflow operators.
// Optional occupancy output port enabled by defining DATAFLOW_ELASTIC_FIFO_COUNT_EN.
module dataflow_elastic_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef DATAFLOW_ELASTIC_FIFO_COUNT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`else
`endif
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push, pop;

   // Handshake outputs depend only on registered state (plus reset for in_ready)
   assign in_ready  = rst_n && (cnt_q != FULL);
   assign out_valid = cnt_q != '0;
   assign out_data  = mem_q[rd_q];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Pointer wrap is explicit so non-power-of-two depths cycle exactly
   always_comb begin
      wr_d  = push ? ((wr_q == LAST) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d  = pop ? ((rd_q == LAST) ? '0 : rd_q + 1'b1) : rd_q;
      cnt_d = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
   end

   // Control state; reset discards any stored tokens
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Token storage is data-only and needs no reset
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= in_data;
   end

`ifdef DATAFLOW_ELASTIC_FIFO_COUNT_EN
   assign occupancy = cnt_q;
`else
`endif
endmodule

// File: tb/tb_dataflow_elastic_fifo.sv
// tb_dataflow_elastic_fifo: scoreboard bench for a DEPTH=4 and a DEPTH=3 instance.
module tb_dataflow_elastic_fifo;
   logic        clk = 0, rst_n = 0;
   logic        iv4 = 0, ir4, ov4, or4 = 0;
   logic [31:0] id4 = 0, od4;
   logic        iv3 = 0, ir3, ov3, or3 = 0;
   logic [31:0] id3 = 0, od3;
`ifdef DATAFLOW_ELASTIC_FIFO_COUNT_EN
   logic [2:0]  occ4;
   logic [1:0]  occ3;
`endif
   int errors = 0, checks = 0;
   logic [31:0] q[$];
   int mc = 0, cyc = 0;
   bit did_push, did_pop;

   always #5 clk = ~clk;

   dataflow_elastic_fifo #(.WIDTH(32), .DEPTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4)
`ifdef DATAFLOW_ELASTIC_FIFO_COUNT_EN
      , .occupancy(occ4)
`endif
   );
   dataflow_elastic_fifo #(.WIDTH(32), .DEPTH(3)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
      .out_valid(ov3), .out_ready(or3), .out_data(od3)
`ifdef DATAFLOW_ELASTIC_FIFO_COUNT_EN
      , .occupancy(occ3)
`endif
   );

   // One clock: check handshake outputs against the model, then score any transfer
   task automatic step(input bit s);
      logic ir, ov, iv, ordy;
      logic [31:0] od, id, exp;
      int dep;
      @(negedge clk);
      ir = s ? ir3 : ir4; ov = s ? ov3 : ov4; od = s ? od3 : od4;
      iv = s ? iv3 : iv4; id = s ? id3 : id4; ordy = s ? or3 : or4;
      dep = s ? 3 : 4;
      checks++;
      if (ir !== (mc != dep)) begin errors++; $display("FAIL in_ready cyc=%0d dut=%b exp=%b", cyc, ir, mc != dep); end
      checks++;
      if (ov !== (mc != 0)) begin errors++; $display("FAIL out_valid cyc=%0d dut=%b exp=%b", cyc, ov, mc != 0); end
`ifdef DATAFLOW_ELASTIC_FIFO_COUNT_EN
      checks++;
      if ((s ? int'(occ3) : int'(occ4)) != mc) begin
         errors++; $display("FAIL occupancy cyc=%0d dut=%0d exp=%0d", cyc, s ? int'(occ3) : int'(occ4), mc);
      end
`endif
      did_push = iv && ir;
      did_pop  = ov && ordy;
      if (did_pop) begin
         checks++;
         if (q.size() == 0) begin
            errors++; $display("FAIL underflow cyc=%0d dut_data=%h exp=none", cyc, od);
         end else begin
            exp = q.pop_front();
            if (od !== exp) begin errors++; $display("FAIL out_data cyc=%0d dut=%h exp=%h", cyc, od, exp); end
         end
      end
      if (did_push) q.push_back(id);
      mc = q.size();
      cyc++;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      iv4 = 0; or4 = 0; iv3 = 0; or3 = 0;
      rst_n = 0;
      q.delete(); mc = 0;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (ir4 !== 1'b0 || ov4 !== 1'b0) begin errors++; $display("FAIL reset_hold in_ready=%b out_valid=%b exp=0,0", ir4, ov4); end
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      checks++;
      if (ir4 !== 1'b1 || ov4 !== 1'b0) begin errors++; $display("FAIL reset_release in_ready=%b out_valid=%b exp=1,0", ir4, ov4); end
   endtask

   task automatic test_midstream_reset();
      or4 = 0; iv4 = 1;
      id4 = 32'hA1; step(0);
      id4 = 32'hA2; step(0);
      iv4 = 0;
      #2 rst_n = 0;
      #1;
      checks++;
      if (ov4 !== 1'b0 || ir4 !== 1'b0) begin errors++; $display("FAIL mid_reset out_valid=%b in_ready=%b exp=0,0", ov4, ir4); end
      q.delete(); mc = 0;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      or4 = 1;
      repeat (4) step(0);
   endtask

   task automatic test_single_token();
      do_reset();
      or4 = 1; iv4 = 1; id4 = 32'hDEADBEEF;
      step(0);
      iv4 = 0;
      checks++;
      if (ov4 !== 1'b1 || od4 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_n1 out_valid=%b data=%h exp=1,deadbeef", ov4, od4); end
      step(0);
      checks++;
      if (!did_pop) begin errors++; $display("FAIL single_pop popped=%b exp=1", did_pop); end
      step(0);
   endtask

   task automatic test_fill_backpressure();
      int k = 1, t = 0;
      do_reset();
      or4 = 0; iv4 = 1;
      while (k <= 4 && t < 20) begin id4 = k; step(0); if (did_push) k++; t++; end
      checks++;
      if (ir4 !== 1'b0) begin errors++; $display("FAIL full_in_ready dut=%b exp=0", ir4); end
      id4 = 5;
      repeat (3) step(0);
      or4 = 1;
      t = 0;
      while ((iv4 || q.size() != 0) && t < 40) begin
         step(0);
         if (did_push) iv4 = 0;
         t++;
      end
      if (t >= 40) begin errors++; $display("FAIL fill_timeout cycles=%0d exp<40", t); end
   endtask

   task automatic test_back_to_back();
      int pushes = 0, pops = 0, t = 0, first = -1, last = -1;
      do_reset();
      or4 = 1; iv4 = 1;
      while (pops < 100 && t < 300) begin
         id4 = pushes;
         step(0);
         if (did_push) pushes++;
         if (did_pop) begin pops++; if (first < 0) first = t; last = t; end
         if (pushes == 100) iv4 = 0;
         checks++;
         if (mc > 1) begin errors++; $display("FAIL stream_count count=%0d exp<=1", mc); end
         t++;
      end
      checks++;
      if (pops != 100 || first != 1 || last - first != 99) begin
         errors++; $display("FAIL stream_rate pops=%0d first=%0d span=%0d exp=100,1,99", pops, first, last - first);
      end
   endtask

   task automatic test_wrap_random();
      int pushes = 0, pops = 0, t = 0;
      do_reset();
      while (pops < 1000 && t < 20000) begin
         if (!iv3 && pushes < 1000) iv3 = 1'($urandom_range(0, 1));
         id3 = pushes;
         or3 = 1'($urandom_range(0, 1));
         step(1);
         if (did_push) begin pushes++; iv3 = 0; end
         if (did_pop) pops++;
         t++;
      end
      checks++;
      if (pops != 1000 || q.size() != 0) begin errors++; $display("FAIL wrap_total pops=%0d left=%0d exp=1000,0", pops, q.size()); end
   endtask

`ifdef DATAFLOW_ELASTIC_FIFO_COUNT_EN
   task automatic test_occupancy();
      do_reset();
      or4 = 0; iv4 = 1;
      for (int i = 0; i < 3; i++) begin id4 = 32'h100 + i; step(0); end
      or4 = 1; id4 = 32'h103;
      step(0);
      iv4 = 0;
      checks++;
      if (occ4 !== 3'd3) begin errors++; $display("FAIL occ_hold dut=%0d exp=3", occ4); end
      repeat (4) step(0);
      checks++;
      if (occ4 !== 3'd0) begin errors++; $display("FAIL occ_drain dut=%0d exp=0", occ4); end
   endtask
`endif

   initial begin
      test_reset();
      test_midstream_reset();
      test_single_token();
      test_fill_backpressure();
      test_back_to_back();
      test_wrap_random();
`ifdef DATAFLOW_ELASTIC_FIFO_COUNT_EN
      test_occupancy();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dataflow_elastic_fifo.md
Name: dataflow_elastic_fifo

Overview:
Synchronous valid/ready elastic buffer that sits between two dataflow operator modules (e.g. the LLVM-op library units).
- Receives the producer's result stream and re-presents it to the consumer.
- Breaks the combinational ready/valid path that chains of combinational ops create.
- Absorbs up to DEPTH tokens of backpressure slack.
- Acts as the registered receiving end of the same handshake the combinational ops drive.

Parameters:
WIDTH, 32, data bits per token (>=1)
DEPTH, 2, token storage entries (>=2; need not be a power of two)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  producer token valid
in_ready  output  1  buffer can accept a token this cycle
in_data  input  WIDTH  producer token data
out_valid  output  1  buffer holds a token for the consumer
out_ready  input  1  consumer accepts the token this cycle
out_data  output  WIDTH  head token data

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Handshake: a transfer occurs on an edge where valid && ready on the same port. Producer and consumer must hold valid/data stable until accepted; the buffer itself obeys this on the out port.
- State:
  - rd_ptr, wr_ptr: 0..DEPTH-1.
  - count: 0..DEPTH.
  - Storage array: not reset.
- Reset (rst_n low, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0, out_valid=0.
  - in_ready=0 while rst_n is low. in_ready goes 1 in the first cycle after deassertion.
  - out_data is don't-care while out_valid=0.
  - Reset mid-stream discards all stored tokens with no output transfer.
- Outputs (all combinational from registered state only):
  - in_ready = rst_n && (count != DEPTH).
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr].
  - No combinational path exists from out_ready to in_ready, or from in_valid/in_data to out_valid/out_data.
- Latency: a token accepted at edge N appears on out_data with out_valid=1 from just after edge N (visible in cycle N+1). Minimum in-to-out latency is 1 cycle; there is no bypass.
- Push (in_valid && in_ready):
  - mem[wr_ptr] <= in_data.
  - wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
- Pop (out_valid && out_ready):
  - rd_ptr advances with the same wrap rule.
- Count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push+pop or on neither.
- Boundaries:
  - Full (count==DEPTH): in_ready=0, no push; a pop that cycle frees a slot visible next cycle.
  - Empty (count==0): out_valid=0, no pop; a push that cycle shows out_valid=1 next cycle.
  - Simultaneous push+pop at count=1: the new token is written to a different slot, and the head pops.
  - Wrap-around is exact for non-power-of-2 DEPTH (e.g. DEPTH=3: pointer sequence 0,1,2,0).
- Ordering: strict FIFO; no token is lost or duplicated.
- Throughput: 1 token/cycle sustained when in_valid=1 and out_ready=1.

Optional Feature:
Macro: DATAFLOW_ELASTIC_FIFO_COUNT_EN
- Defined: adds output port occupancy [$clog2(DEPTH+1)-1:0] equal to the internal count register.
  - Reset value is 0.
  - The port is placed after out_data.
  - occupancy updates on the same edge as push/pop.
- Undefined: the port and any logic driving it are absent. All other behaviour is identical.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle with 2 tokens stored -> out_valid=0 and in_ready=0 immediately; after release in_ready=1, out_valid=0, no stale token ever emerges.
- Single token, WIDTH=32: push 0xDEADBEEF at edge N with out_ready=1 -> out_valid=1 and out_data=0xDEADBEEF in cycle N+1; popped at edge N+1; out_valid=0 in cycle N+2.
- Fill/backpressure, DEPTH=4: out_ready=0, push 1,2,3,4 -> in_ready=0 after the 4th; 5th held; raise out_ready -> outputs 1,2,3,4,5 in order; in_ready returns 1 the cycle after the first pop.
- Full-rate streaming: in_valid=1, out_ready=1, push 0..99 -> 100 outputs 0..99 in consecutive cycles after the 1-cycle latency; count never exceeds 1.
- Wrap, DEPTH=3: random valid/ready (50% each) for 1000 tokens with incrementing data -> scoreboard exact order; pointers pass 2->0 repeatedly; no overflow or underflow.
- With DATAFLOW_ELASTIC_FIFO_COUNT_EN, DEPTH=4: push 3 with out_ready=0 -> occupancy 1,2,3. A simultaneous push+pop then holds occupancy at 3. Draining -> occupancy reaches 0.
